id_stage: RTL

- Instruction-decode stage of the 5-stage MIPS pipeline. It consumes the IF/ID register (PC_plus_4, Instruction) and drives the IF stage's control inputs (IFIDop, IDEXop, PCSrc, jPC, jrPC, branchPC, comp_true).
- Decodes the instruction, reads the external register file, resolves branches and jumps in ID, detects hazards, and owns the ID/EX pipeline register.

---
 rtl/mips_pkg.sv | 117 +++++++++++
 rtl/id_decoder.sv | 156 +++++++++++++++
 rtl/id_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct codes, ALU operation encoding,
// pipeline-control encodings and the decoded-instruction / ID-EX records.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IFID_ADVANCE = 2'd0,
    IFID_FLUSH   = 2'd1,
    IFID_HOLD    = 2'd2
  } ifid_op_e;

  typedef enum logic [1:0] {
    IDEX_ADVANCE = 2'd0,
    IDEX_BUBBLE  = 2'd1,
    IDEX_HOLD    = 2'd2
  } idex_op_e;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'd0,
    PCSRC_BRANCH = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_JREG   = 2'd3
  } pcsrc_e;

  // Everything the ID stage needs to know about one instruction.
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [31:0] imm_ext;
    alu_op_e     alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        link;
    logic [4:0]  dest;
    logic        uses_rs;
    logic        uses_rt;
    logic        is_branch;
    logic        is_bne;
    logic        is_jump;
    logic        is_jreg;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        link;
  } idex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Pure combinational instruction decoder: instruction word -> control fields.
// Unsupported encodings decode as a nop with every write/memory flag clear.
module id_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] dest;
  logic       writes;
  logic       imm_alu;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign rt     = instr_i[20:16];
  assign rd     = instr_i[15:11];

  always_comb begin
    dec_o         = '0;
    dec_o.rs      = instr_i[25:21];
    dec_o.rt      = rt;
    dec_o.shamt   = instr_i[10:6];
    dec_o.imm_ext = sext16(instr_i[15:0]);
    dec_o.alu_op  = ALU_ADD;
    dest          = 5'd0;
    writes        = 1'b0;
    imm_alu       = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        dest          = rd;
        writes        = 1'b1;
        dec_o.uses_rs = 1'b1;
        dec_o.uses_rt = 1'b1;
        case (funct)
          F_ADD, F_ADDU: dec_o.alu_op = ALU_ADD;
          F_SUB, F_SUBU: dec_o.alu_op = ALU_SUB;
          F_AND:         dec_o.alu_op = ALU_AND;
          F_OR:          dec_o.alu_op = ALU_OR;
          F_XOR:         dec_o.alu_op = ALU_XOR;
          F_NOR:         dec_o.alu_op = ALU_NOR;
          F_SLT:         dec_o.alu_op = ALU_SLT;
          F_SLTU:        dec_o.alu_op = ALU_SLTU;
          F_SLL: begin
            dec_o.alu_op  = ALU_SLL;
            dec_o.uses_rs = 1'b0;
          end
          F_SRL: begin
            dec_o.alu_op  = ALU_SRL;
            dec_o.uses_rs = 1'b0;
          end
          F_SRA: begin
            dec_o.alu_op  = ALU_SRA;
            dec_o.uses_rs = 1'b0;
          end
          F_JR: begin
            writes        = 1'b0;
            dec_o.uses_rt = 1'b0;
            dec_o.is_jreg = 1'b1;
          end
          F_JALR: begin
            dec_o.uses_rt = 1'b0;
            dec_o.is_jreg = 1'b1;
            dec_o.link    = 1'b1;
          end
          default: begin
            writes        = 1'b0;
            dec_o.uses_rs = 1'b0;
            dec_o.uses_rt = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        imm_alu       = 1'b1;
        dec_o.uses_rs = 1'b1;
      end
      OP_SLTI: begin
        imm_alu       = 1'b1;
        dec_o.uses_rs = 1'b1;
        dec_o.alu_op  = ALU_SLT;
      end
      OP_SLTIU: begin
        imm_alu       = 1'b1;
        dec_o.uses_rs = 1'b1;
        dec_o.alu_op  = ALU_SLTU;
      end
      OP_ANDI: begin
        imm_alu       = 1'b1;
        dec_o.uses_rs = 1'b1;
        dec_o.alu_op  = ALU_AND;
        dec_o.imm_ext = {16'h0000, instr_i[15:0]};
      end
      OP_ORI: begin
        imm_alu       = 1'b1;
        dec_o.uses_rs = 1'b1;
        dec_o.alu_op  = ALU_OR;
        dec_o.imm_ext = {16'h0000, instr_i[15:0]};
      end
      OP_XORI: begin
        imm_alu       = 1'b1;
        dec_o.uses_rs = 1'b1;
        dec_o.alu_op  = ALU_XOR;
        dec_o.imm_ext = {16'h0000, instr_i[15:0]};
      end
      OP_LUI: begin
        imm_alu      = 1'b1;
        dec_o.alu_op = ALU_LUI;
      end
      OP_LW: begin
        dest             = rt;
        writes           = 1'b1;
        dec_o.alu_src    = 1'b1;
        dec_o.mem_read   = 1'b1;
        dec_o.mem_to_reg = 1'b1;
        dec_o.uses_rs    = 1'b1;
      end
      OP_SW: begin
        dec_o.alu_src   = 1'b1;
        dec_o.mem_write = 1'b1;
        dec_o.uses_rs   = 1'b1;
        dec_o.uses_rt   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_o.alu_op    = ALU_SUB;
        dec_o.is_branch = 1'b1;
        dec_o.is_bne    = (opcode == OP_BNE);
        dec_o.uses_rs   = 1'b1;
        dec_o.uses_rt   = 1'b1;
      end
      OP_J: dec_o.is_jump = 1'b1;
      OP_JAL: begin
        dest          = REG_RA;
        writes        = 1'b1;
        dec_o.is_jump = 1'b1;
        dec_o.link    = 1'b1;
      end
      default: ;
    endcase

    if (imm_alu) begin
      dest          = rt;
      writes        = 1'b1;
      dec_o.alu_src = 1'b1;
    end

    // $0 is never written; a suppressed write also reports no destination.
    dec_o.reg_write = writes && (dest != 5'd0);
    dec_o.dest      = dec_o.reg_write ? dest : 5'd0;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, register read, branch/jump resolution
// with MEM-stage forwarding, hazard detection, and the ID/EX pipeline register.
module id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC_PLUS_4 = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_plus_4,
  input  logic [31:0] Instruction,
  input  logic        stall_in,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        ex_RegWrite,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rd,
  input  logic        mem_RegWrite,
  input  logic        mem_MemRead,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_wdata,
  output logic [1:0]  IFIDop,
  output logic [1:0]  IDEXop,
  output logic [1:0]  PCSrc,
  output logic        comp_true,
  output logic [31:0] branchPC,
  output logic [31:0] jPC,
  output logic [31:0] jrPC,
  output logic [31:0] idex_PC_plus_4,
  output logic [31:0] idex_rs_data,
  output logic [31:0] idex_rt_data,
  output logic [31:0] idex_imm_ext,
  output logic [4:0]  idex_rs,
  output logic [4:0]  idex_rt,
  output logic [4:0]  idex_rd,
  output logic [4:0]  idex_shamt,
  output logic [3:0]  idex_ALUOp,
  output logic        idex_RegWrite,
  output logic        idex_MemRead,
  output logic        idex_MemWrite,
  output logic        idex_MemtoReg,
  output logic        idex_ALUSrc,
  output logic        idex_Link
);

  dec_t dec;

  id_decoder u_decoder (
    .instr_i (Instruction),
    .dec_o   (dec)
  );

  assign rf_raddr1 = dec.rs;
  assign rf_raddr2 = dec.rt;

  logic ex_match_rs, ex_match_rt, mem_match_rs, mem_match_rt;
  assign ex_match_rs  = (ex_rd != 5'd0) && (ex_rd == dec.rs);
  assign ex_match_rt  = (ex_rd != 5'd0) && (ex_rd == dec.rt);
  assign mem_match_rs = (mem_rd != 5'd0) && (mem_rd == dec.rs);
  assign mem_match_rt = (mem_rd != 5'd0) && (mem_rd == dec.rt);

  // Only a MEM-stage ALU result is ready in time; loads in MEM are stalled on.
  logic        fwd_rs, fwd_rt;
  logic [31:0] rs_val, rt_val;
  assign fwd_rs = mem_RegWrite && !mem_MemRead && mem_match_rs;
  assign fwd_rt = mem_RegWrite && !mem_MemRead && mem_match_rt;
  assign rs_val = fwd_rs ? mem_wdata : rf_rdata1;
  assign rt_val = fwd_rt ? mem_wdata : rf_rdata2;

  assign branchPC = PC_plus_4 + (sext16(Instruction[15:0]) << 2);
  assign jPC      = {PC_plus_4[31:28], Instruction[25:0], 2'b00};
  assign jrPC     = rs_val;

  logic load_use, ctl_hz_rs, ctl_hz_rt, ctl_hazard, branch_taken;
  assign load_use   = ex_MemRead &&
                      ((dec.uses_rs && ex_match_rs) || (dec.uses_rt && ex_match_rt));
  assign ctl_hz_rs  = (ex_RegWrite && ex_match_rs) || (mem_MemRead && mem_match_rs);
  assign ctl_hz_rt  = (ex_RegWrite && ex_match_rt) || (mem_MemRead && mem_match_rt);
  assign ctl_hazard = ((dec.is_branch || dec.is_jreg) && ctl_hz_rs) ||
                      (dec.is_branch && ctl_hz_rt);
  assign branch_taken = dec.is_branch && ((rs_val == rt_val) != dec.is_bne);

  ifid_op_e ifid_op;
  idex_op_e idex_op;
  pcsrc_e   pc_src;
  logic     comp;

  always_comb begin
    ifid_op = IFID_ADVANCE;
    idex_op = IDEX_ADVANCE;
    pc_src  = PCSRC_SEQ;
    comp    = 1'b0;
    if (stall_in) begin
      ifid_op = IFID_HOLD;
      idex_op = IDEX_HOLD;
    end else if (load_use || ctl_hazard) begin
      ifid_op = IFID_HOLD;
      idex_op = IDEX_BUBBLE;
    end else if (dec.is_jump) begin
      pc_src  = PCSRC_JUMP;
      ifid_op = IFID_FLUSH;
    end else if (dec.is_jreg) begin
      pc_src  = PCSRC_JREG;
      ifid_op = IFID_FLUSH;
    end else if (dec.is_branch) begin
      pc_src = PCSRC_BRANCH;
      if (branch_taken) begin
        comp    = 1'b1;
        ifid_op = IFID_FLUSH;
      end
    end
  end

  assign IFIDop    = ifid_op;
  assign IDEXop    = idex_op;
  assign PCSrc     = pc_src;
  assign comp_true = comp;

  idex_t idex_q, idex_d, idex_rst, idex_dec;

  always_comb begin
    idex_rst           = '0;
    idex_rst.pc_plus_4 = RESET_PC_PLUS_4;
  end

  always_comb begin
    idex_dec            = '0;
    idex_dec.pc_plus_4  = PC_plus_4;
    idex_dec.rs_data    = rf_rdata1;
    idex_dec.rt_data    = rf_rdata2;
    idex_dec.imm_ext    = dec.imm_ext;
    idex_dec.rs         = dec.rs;
    idex_dec.rt         = dec.rt;
    idex_dec.rd         = dec.dest;
    idex_dec.shamt      = dec.shamt;
    idex_dec.alu_op     = dec.alu_op;
    idex_dec.reg_write  = dec.reg_write;
    idex_dec.mem_read   = dec.mem_read;
    idex_dec.mem_write  = dec.mem_write;
    idex_dec.mem_to_reg = dec.mem_to_reg;
    idex_dec.alu_src    = dec.alu_src;
    idex_dec.link       = dec.link;
  end

  always_comb begin
    idex_d = idex_dec;
    case (idex_op)
      IDEX_BUBBLE: idex_d = idex_rst;
      IDEX_HOLD:   idex_d = idex_q;
      default:     idex_d = idex_dec;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) idex_q <= idex_rst;
    else       idex_q <= idex_d;
  end

  assign idex_PC_plus_4 = idex_q.pc_plus_4;
  assign idex_rs_data   = idex_q.rs_data;
  assign idex_rt_data   = idex_q.rt_data;
  assign idex_imm_ext   = idex_q.imm_ext;
  assign idex_rs        = idex_q.rs;
  assign idex_rt        = idex_q.rt;
  assign idex_rd        = idex_q.rd;
  assign idex_shamt     = idex_q.shamt;
  assign idex_ALUOp     = idex_q.alu_op;
  assign idex_RegWrite  = idex_q.reg_write;
  assign idex_MemRead   = idex_q.mem_read;
  assign idex_MemWrite  = idex_q.mem_write;
  assign idex_MemtoReg  = idex_q.mem_to_reg;
  assign idex_ALUSrc    = idex_q.alu_src;
  assign idex_Link      = idex_q.link;

endmodule
